// File: rtl/handshake_const_sink.sv
// handshake_const_sink
//   Consumes data tokens over a valid/ready channel and, for each one, emits a
//   dataless control token over a second valid/ready channel. The control
//   token carries ctrl_match, which says whether the consumed payload equalled
//   CONST_VALUE. A single output register decouples the two channels. It still
//   allows one token per cycle, because a new token can be accepted in the
//   same cycle that the buffered one leaves.
//
// Ports
//   clk            : sole clock, rising edge
//   rst            : synchronous active-high reset
//   ins            : data token payload
//   ins_valid      : data token present
//   ins_ready      : sink accepts the data token this cycle (comb. from ctrl_ready)
//   ctrl_valid     : control token present (registered)
//   ctrl_ready     : downstream accepts the control token
//   ctrl_match     : qualifier travelling with the control token (registered)
//   token_count    : saturating count of accepted data tokens
//   mismatch_count : saturating count of accepted tokens that were not CONST_VALUE
//   mismatch_seen  : sticky flag, set by the first mismatching accepted token
module handshake_const_sink #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [63:0] CONST_VALUE = 64'd535809,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  ctrl_valid,
  input  logic                  ctrl_ready,
  output logic                  ctrl_match,
  output logic [CNT_WIDTH-1:0]  token_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  mismatch_seen
);

  localparam logic [DATA_WIDTH-1:0] ConstW   = DATA_WIDTH'(CONST_VALUE);
  localparam logic [CNT_WIDTH-1:0]  CntMax   = {CNT_WIDTH{1'b1}};

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                 state_q, state_d;
  logic                   match_q, match_d;
  logic [CNT_WIDTH-1:0]   tok_cnt_q, tok_cnt_d;
  logic [CNT_WIDTH-1:0]   mm_cnt_q, mm_cnt_d;
  logic                   mm_seen_q, mm_seen_d;

  logic in_xfer;
  logic out_xfer;
  logic is_match;

  // The buffer can take a token whenever it is empty or is being drained now.
  assign ins_ready = (state_q == StEmpty) || ctrl_ready;
  assign in_xfer   = ins_valid && ins_ready;
  assign out_xfer  = (state_q == StFull) && ctrl_ready;
  assign is_match  = (ins == ConstW);

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    tok_cnt_d = tok_cnt_q;
    mm_cnt_d  = mm_cnt_q;
    mm_seen_d = mm_seen_q;

    unique case (state_q)
      StEmpty: if (in_xfer) state_d = StFull;
      StFull: begin
        // Simultaneous drain and fill keeps the buffer full with no bubble.
        if (out_xfer && !in_xfer) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase

    if (in_xfer) begin
      match_d = is_match;
      if (tok_cnt_q != CntMax) tok_cnt_d = tok_cnt_q + CNT_WIDTH'(1);
      if (!is_match) begin
        mm_seen_d = 1'b1;
        if (mm_cnt_q != CntMax) mm_cnt_d = mm_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      match_q   <= 1'b0;
      tok_cnt_q <= '0;
      mm_cnt_q  <= '0;
      mm_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      tok_cnt_q <= tok_cnt_d;
      mm_cnt_q  <= mm_cnt_d;
      mm_seen_q <= mm_seen_d;
    end
  end

  assign ctrl_valid     = (state_q == StFull);
  assign ctrl_match     = match_q;
  assign token_count    = tok_cnt_q;
  assign mismatch_count = mm_cnt_q;
  assign mismatch_seen  = mm_seen_q;

endmodule
